// File: rtl/writeback_seq_pkg.sv
// Shared definitions for the writeback sequencer: write-data source codes,
// sequencer state encodings and source classification.
package writeback_seq_pkg;

    // Write-data mux source codes; 3'b111 is undefined at the mux.
    localparam logic [2:0] WB_SRC_ALUOUT     = 3'b000;
    localparam logic [2:0] WB_SRC_LSC        = 3'b001;
    localparam logic [2:0] WB_SRC_MDR        = 3'b010;
    localparam logic [2:0] WB_SRC_HI         = 3'b011;
    localparam logic [2:0] WB_SRC_LO         = 3'b100;
    localparam logic [2:0] WB_SRC_CONST      = 3'b101;
    localparam logic [2:0] WB_SRC_ALUOUT_REG = 3'b110;
    localparam logic [2:0] WB_SRC_ILLEGAL    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_WAIT_MD  = 2'b10,
        ST_WRITE    = 2'b11
    } wb_state_e;

    // How long a source needs before its data can be written.
    typedef enum logic [1:0] {
        CLS_DIRECT  = 2'b00,
        CLS_MEM     = 2'b01,
        CLS_MD      = 2'b10,
        CLS_ILLEGAL = 2'b11
    } wb_src_class_e;

    function automatic wb_src_class_e src_class(input logic [2:0] src);
        wb_src_class_e cls;
        case (src)
            WB_SRC_ALUOUT, WB_SRC_CONST, WB_SRC_ALUOUT_REG: cls = CLS_DIRECT;
            WB_SRC_LSC, WB_SRC_MDR:                         cls = CLS_MEM;
            WB_SRC_HI, WB_SRC_LO:                           cls = CLS_MD;
            default:                                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/wb_down_counter.sv
// Loadable down-counter that stops at zero; used for memory latency and
// mult/div timeout waits.
module wb_down_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/writeback_seq.sv
// Register-file writeback sequencer: accepts one request, waits for the
// source data to be valid, then presents a stable mux selector and pulses
// reg_write for a single cycle.
//
// state       | meaning
// ST_IDLE     | ready for a request; selector and address parked at 0
// ST_WAIT_MEM | load data in flight, counting down memory latency
// ST_WAIT_MD  | waiting for mult/div result, counting down the timeout
// ST_WRITE    | single write cycle (write suppressed for $0)
module writeback_seq
    import writeback_seq_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [2:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic       md_done,
    input  logic       flush,
    output logic       wb_ack,
    output logic       busy,
    output logic [2:0] wd_sel,
    output logic [4:0] wr_addr,
    output logic       reg_write,
    output logic       wb_done,
    output logic       wb_err
);

    localparam int CNT_MAX = (MEM_LAT > MD_TIMEOUT) ? MEM_LAT : MD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    wb_state_e     state_q;
    logic [2:0]    wd_sel_q;
    logic [4:0]    wr_addr_q;
    logic          reg_write_q;
    logic          wb_done_q;
    logic          wb_err_q;
    logic          busy_q;

    logic          accept;
    wb_src_class_e req_cls;
    logic          cnt_load;
    logic          cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic          cnt_zero;
    logic          unused_cnt_value;

    // Accept decode and counter control; flush blocks acceptance.
    always_comb begin
        req_cls      = src_class(wb_src);
        accept       = (state_q == ST_IDLE) && wb_req && !flush;
        cnt_load     = accept && ((req_cls == CLS_MEM) || (req_cls == CLS_MD));
        cnt_load_val = (req_cls == CLS_MEM) ? CNT_W'(MEM_LAT - 1) : CNT_W'(MD_TIMEOUT - 1);
        cnt_en       = (state_q == ST_WAIT_MEM) || (state_q == ST_WAIT_MD);
    end

    wb_down_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .enable   (cnt_en),
        .load_val (cnt_load_val),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // The full count is only observed through the zero flag.
    assign unused_cnt_value = ^cnt_value;

    // Sequencer FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wd_sel_q    <= WB_SRC_ALUOUT;
            wr_addr_q   <= '0;
            reg_write_q <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wd_sel_q  <= WB_SRC_ALUOUT;
                    wr_addr_q <= '0;
                    busy_q    <= 1'b0;
                    if (accept) begin
                        case (req_cls)
                            CLS_DIRECT: begin
                                state_q     <= ST_WRITE;
                                busy_q      <= 1'b1;
                                wd_sel_q    <= wb_src;
                                wr_addr_q   <= wb_dst;
                                reg_write_q <= (wb_dst != '0);
                                wb_done_q   <= 1'b1;
                            end
                            CLS_MEM: begin
                                state_q   <= ST_WAIT_MEM;
                                busy_q    <= 1'b1;
                                wd_sel_q  <= wb_src;
                                wr_addr_q <= wb_dst;
                            end
                            CLS_MD: begin
                                state_q   <= ST_WAIT_MD;
                                busy_q    <= 1'b1;
                                wd_sel_q  <= wb_src;
                                wr_addr_q <= wb_dst;
                            end
                            default: begin
                                // Illegal selector is never latched onto the mux.
                                wb_err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT_MEM: begin
                    if (flush) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        wd_sel_q  <= WB_SRC_ALUOUT;
                        wr_addr_q <= '0;
                    end else if (cnt_zero) begin
                        state_q     <= ST_WRITE;
                        reg_write_q <= (wr_addr_q != '0);
                        wb_done_q   <= 1'b1;
                    end
                end
                ST_WAIT_MD: begin
                    if (flush) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        wd_sel_q  <= WB_SRC_ALUOUT;
                        wr_addr_q <= '0;
                    end else if (md_done) begin
                        // md_done beats a timeout expiring in the same cycle.
                        state_q     <= ST_WRITE;
                        reg_write_q <= (wr_addr_q != '0);
                        wb_done_q   <= 1'b1;
                    end else if (cnt_zero) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        wd_sel_q  <= WB_SRC_ALUOUT;
                        wr_addr_q <= '0;
                        wb_err_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    wd_sel_q  <= WB_SRC_ALUOUT;
                    wr_addr_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ack    = accept && !reset;
    assign busy      = busy_q;
    assign wd_sel    = wd_sel_q;
    assign wr_addr   = wr_addr_q;
    assign reg_write = reg_write_q;
    assign wb_done   = wb_done_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_writeback_seq.sv
// Directed bench for the writeback sequencer (MEM_LAT=2, MD_TIMEOUT=40).
module tb_writeback_seq;

    logic       clk;
    logic       reset;
    logic       wb_req;
    logic [2:0] wb_src;
    logic [4:0] wb_dst;
    logic       md_done;
    logic       flush;
    logic       wb_ack;
    logic       busy;
    logic [2:0] wd_sel;
    logic [4:0] wr_addr;
    logic       reg_write;
    logic       wb_done;
    logic       wb_err;

    int n_checks = 0;
    int n_errors = 0;

    writeback_seq #(
        .MEM_LAT    (2),
        .MD_TIMEOUT (40)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_req    (wb_req),
        .wb_src    (wb_src),
        .wb_dst    (wb_dst),
        .md_done   (md_done),
        .flush     (flush),
        .wb_ack    (wb_ack),
        .busy      (busy),
        .wd_sel    (wd_sel),
        .wr_addr   (wr_addr),
        .reg_write (reg_write),
        .wb_done   (wb_done),
        .wb_err    (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; md_at = cycle after accept where md_done goes high (-1 never).
    task automatic run_vec(input string tag, input logic [2:0] src, input logic [4:0] dst,
                           input int md_at, input int exp_lat, input logic exp_we,
                           input logic exp_err, input logic [2:0] exp_sel);
        int lat;
        bit seen;
        wb_req  = 1'b1;
        wb_src  = src;
        wb_dst  = dst;
        md_done = (md_at == 0);
        #1;
        check_val($sformatf("%s.ack", tag), wb_ack, 1);
        step();
        wb_req = 1'b0;
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 60) begin
            md_done = (md_at >= 0) && (lat >= md_at);
            #1;
            if (lat == 1) begin
                check_val($sformatf("%s.busy1", tag), busy, (src != 3'b111));
                check_val($sformatf("%s.sel1", tag), wd_sel, (src == 3'b111) ? 3'b000 : src);
            end
            if (reg_write || wb_done || wb_err) seen = 1;
            else begin
                step();
                lat++;
            end
        end
        check_val($sformatf("%s.lat", tag), lat, exp_lat);
        check_val($sformatf("%s.we", tag), reg_write, exp_we);
        check_val($sformatf("%s.done", tag), wb_done, !exp_err);
        check_val($sformatf("%s.err", tag), wb_err, exp_err);
        check_val($sformatf("%s.sel", tag), wd_sel, exp_sel);
        check_val($sformatf("%s.addr", tag), wr_addr, exp_err ? 5'd0 : dst);
        md_done = 1'b0;
        step();
        check_val($sformatf("%s.we_end", tag), reg_write, 0);
        check_val($sformatf("%s.busy_end", tag), busy, 0);
        check_val($sformatf("%s.sel_end", tag), wd_sel, 0);
    endtask

    initial begin
        int we_seen;
        reset   = 1'b1;
        wb_req  = 1'b1;
        wb_src  = 3'b000;
        wb_dst  = 5'd1;
        md_done = 1'b0;
        flush   = 1'b0;
        step();
        step();
        check_val("rst.ack", wb_ack, 0);
        check_val("rst.busy", busy, 0);
        check_val("rst.sel", wd_sel, 0);
        check_val("rst.addr", wr_addr, 0);
        check_val("rst.we", reg_write, 0);
        check_val("rst.done", wb_done, 0);
        check_val("rst.err", wb_err, 0);
        wb_req = 1'b0;
        reset  = 1'b0;
        step();

        //       tag       src     dst  md_at lat we err sel
        run_vec("alu",    3'b000, 5'd8,  -1,  1, 1, 0, 3'b000);
        run_vec("mdr",    3'b010, 5'd4,  -1,  3, 1, 0, 3'b010);
        run_vec("lsc",    3'b001, 5'd31, -1,  3, 1, 0, 3'b001);
        run_vec("hi",     3'b011, 5'd2,   5,  6, 1, 0, 3'b011);
        run_vec("lo_imm", 3'b100, 5'd7,   1,  2, 1, 0, 3'b100);
        run_vec("lo_to",  3'b100, 5'd9,  -1, 41, 0, 1, 3'b000);
        run_vec("md_tie", 3'b011, 5'd12, 40, 41, 1, 0, 3'b011);
        run_vec("r0",     3'b110, 5'd0,  -1,  1, 0, 0, 3'b110);
        run_vec("const",  3'b101, 5'd3,  -1,  1, 1, 0, 3'b101);
        run_vec("illeg",  3'b111, 5'd5,  -1,  1, 0, 1, 3'b000);

        // flush during WAIT_MEM
        wb_req = 1'b1; wb_src = 3'b010; wb_dst = 5'd4;
        step();
        wb_req = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush.busy", busy, 0);
        check_val("flush.sel", wd_sel, 0);
        check_val("flush.done", wb_done, 0);
        check_val("flush.err", wb_err, 0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (reg_write || wb_done) we_seen++;
            step();
        end
        check_val("flush.nowrite", we_seen, 0);

        // reset during WAIT_MD, with a request held during reset
        wb_req = 1'b1; wb_src = 3'b011; wb_dst = 5'd7;
        step();
        wb_req = 1'b0;
        step();
        reset = 1'b1; wb_req = 1'b1;
        #1;
        check_val("rstmid.ack", wb_ack, 0);
        step();
        wb_req = 1'b0;
        check_val("rstmid.busy", busy, 0);
        check_val("rstmid.sel", wd_sel, 0);
        check_val("rstmid.addr", wr_addr, 0);
        reset = 1'b0; md_done = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (reg_write || busy) we_seen++;
        end
        md_done = 1'b0;
        check_val("rstmid.nowrite", we_seen, 0);

        // flush with request in IDLE: flush wins
        wb_req = 1'b1; flush = 1'b1; wb_src = 3'b000; wb_dst = 5'd6;
        #1;
        check_val("idleflush.ack", wb_ack, 0);
        step();
        check_val("idleflush.busy", busy, 0);
        wb_req = 1'b0; flush = 1'b0;
        step();

        // request held while busy, then accepted back-to-back after WRITE
        wb_req = 1'b1; wb_src = 3'b010; wb_dst = 5'd3;
        step();
        wb_src = 3'b000; wb_dst = 5'd9;
        #1;
        check_val("b2b.ack_busy1", wb_ack, 0);
        step();
        check_val("b2b.ack_busy2", wb_ack, 0);
        step();
        check_val("b2b.we1", reg_write, 1);
        check_val("b2b.addr1", wr_addr, 3);
        check_val("b2b.ack_write", wb_ack, 0);
        step();
        check_val("b2b.ack_idle", wb_ack, 1);
        check_val("b2b.we_gap", reg_write, 0);
        step();
        wb_req = 1'b0;
        check_val("b2b.we2", reg_write, 1);
        check_val("b2b.addr2", wr_addr, 9);
        step();
        check_val("b2b.busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
